// File: rtl/cpu_prog_sequencer_if.sv
// Program-memory and cpu-control bus between the program sequencer and its memory/cpu.
// The master is the sequencer; the slave is the memory plus cpu side.
interface cpu_prog_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_rdata;
  logic [15:0]       cpu_in;
  logic              cpu_load;
  logic              cpu_s;
  logic              cpu_w;

  modport master (
    output mem_addr, mem_rd, cpu_in, cpu_load, cpu_s,
    input  mem_rdata, cpu_w
  );

  modport slave (
    input  mem_addr, mem_rd, cpu_in, cpu_load, cpu_s,
    output mem_rdata, cpu_w
  );
endinterface

// File: rtl/cpu_prog_sequencer.sv
// Autonomous fetch/load/start/complete sequencer driving the lab cpu from program memory.
// Define SEQ_SINGLE_STEP_EN to add a step input that parks the sequencer after each instruction.
module cpu_prog_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int BUSY_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                 step,
`endif
  cpu_prog_sequencer_if.master bus,
  output logic [ADDR_W-1:0]    pc,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_W-1:0]     retired
);

  localparam int TIMER_W = $clog2(BUSY_TIMEOUT + 1);
  // timer_q counts BUSY cycles from 0; the fault flop then reads 1
  // exactly BUSY_TIMEOUT cycles after the cycle carrying the s pulse.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 2);

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_LOAD, S_START, S_BUSY, S_DONE, S_HALT, S_PAUSE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_LOAD, S_START, S_BUSY, S_DONE, S_HALT
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   ret_q, ret_d;
  logic [15:0]        instr_q, instr_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ret_q    <= '0;
      instr_q  <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ret_q    <= ret_d;
      instr_q  <= instr_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ret_d    = ret_q;
    instr_d  = instr_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    timer_d  = timer_q;
    case (state_q)
      S_IDLE:    if (run && !halted_q && !fault_q) state_d = S_FETCH;
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        instr_d = bus.mem_rdata;
        if (bus.mem_rdata[15:13] == 3'b111) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          state_d  = S_LOAD;
        end
      end
      S_LOAD:    state_d = S_START;
      S_START:   if (bus.cpu_w) begin
        timer_d = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (!bus.cpu_w) begin
          state_d = S_DONE;
        end else if (timer_q == TIMER_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE:    if (bus.cpu_w) begin
        pc_d = pc_q + 1'b1;
        if (ret_q != '1) ret_d = ret_q + 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        state_d = S_PAUSE;
`else
        state_d = run ? S_FETCH : S_IDLE;
`endif
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (!run)      state_d = S_IDLE;
        else if (step) state_d = S_FETCH;
      end
`endif
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  // s is qualified by cpu_w so it fires only in the cycle START leaves.
  assign bus.mem_rd   = (state_q == S_FETCH);
  assign bus.cpu_load = (state_q == S_LOAD);
  assign bus.cpu_s    = (state_q == S_START) && bus.cpu_w;
  assign bus.mem_addr = pc_q;
  assign bus.cpu_in   = instr_q;

  assign pc      = pc_q;
  assign halted  = halted_q;
  assign fault   = fault_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_cpu_prog_sequencer.sv
// Directed bench for cpu_prog_sequencer: memory and cpu w-flag models, vector table, corner sequences.
module tb_cpu_prog_sequencer;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset;
  logic run = 1'b0, run2 = 1'b0, step = 1'b0, step2 = 1'b0;
  logic hang = 1'b0;
  always #5 clk = ~clk;

  cpu_prog_sequencer_if #(.ADDR_W(8)) bus ();
  cpu_prog_sequencer_if #(.ADDR_W(2)) bus2 ();

  logic [7:0]  pc;  logic halted,  fault;  logic [15:0] retired;
  logic [1:0]  pc2; logic halted2, fault2; logic [15:0] retired2;

  cpu_prog_sequencer #(.ADDR_W(8), .BUSY_TIMEOUT(T), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .bus(bus), .pc(pc), .halted(halted), .fault(fault), .retired(retired));

  cpu_prog_sequencer #(.ADDR_W(2), .BUSY_TIMEOUT(T), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .run(run2),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step2),
`endif
    .bus(bus2), .pc(pc2), .halted(halted2), .fault(fault2), .retired(retired2));

  // synchronous program memories
  logic [15:0] mem  [256];
  logic [15:0] mem2 [4];
  always @(posedge clk) if (bus.mem_rd)  bus.mem_rdata  <= mem[bus.mem_addr];
  always @(posedge clk) if (bus2.mem_rd) bus2.mem_rdata <= mem2[bus2.mem_addr];

  // cpu model: w drops 2 cycles after s, rises 2 cycles later; hang keeps w high
  logic [1:0] ph, ph2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpu_w <= 1'b1; ph <= 2'd0;
    end else if (ph != 2'd0) begin
      ph <= ph + 2'd1;
      if (ph == 2'd1 && !hang) bus.cpu_w <= 1'b0;
      if (ph == 2'd3) begin bus.cpu_w <= 1'b1; ph <= 2'd0; end
    end else if (bus.cpu_s) ph <= 2'd1;
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus2.cpu_w <= 1'b1; ph2 <= 2'd0;
    end else if (ph2 != 2'd0) begin
      ph2 <= ph2 + 2'd1;
      if (ph2 == 2'd1) bus2.cpu_w <= 1'b0;
      if (ph2 == 2'd3) begin bus2.cpu_w <= 1'b1; ph2 <= 2'd0; end
    end else if (bus2.cpu_s) ph2 <= 2'd1;
  end

  int n_rd = 0, n_ld = 0, n_s = 0, n_ovl = 0;
  logic [15:0] last_ld = '0, last_ld2 = '0;
  always @(negedge clk) begin
    if (bus.mem_rd) n_rd++;
    if (bus.cpu_load) begin n_ld++; last_ld = bus.cpu_in; end
    if (bus.cpu_s) n_s++;
    if (bus2.cpu_load) last_ld2 = bus2.cpu_in;
    if (bus.cpu_load && bus.cpu_s)   n_ovl++;
    if (bus2.cpu_load && bus2.cpu_s) n_ovl++;
    if (bus.mem_rd && (bus.cpu_load || bus.cpu_s)) n_ovl++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic wait_s(input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = bus.cpu_s; end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_rd(input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = bus.mem_rd; end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_ret(input string nm, input int v);
    logic ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin tick(); ok = (int'(retired) >= v); end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [1:0]  exp_pc;
    int          exp_ret;
  } vec_t;
  vec_t vec [5];

  initial begin
    int b_rd, b_ld, b_s, k;
    logic ok;
    vec[0] = '{16'hA000, 2'd1, 1};
    vec[1] = '{16'hA000, 2'd2, 2};
    vec[2] = '{16'hA000, 2'd3, 3};
    vec[3] = '{16'hA000, 2'd0, 4};
    vec[4] = '{16'hA000, 2'd1, 5};
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 5; i++) mem2[i % 4] = vec[i].instr;

    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_strobes", {bus.mem_rd, bus.cpu_load, bus.cpu_s}, 0);
    chk("rst_cpu_in", bus.cpu_in, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_pc2", pc2, 0);

`ifdef SEQ_SINGLE_STEP_EN
    // parks after every instruction; each step pulse advances one
    for (int i = 0; i < 8; i++) mem[i] = 16'hA000;
    run = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      wait_ret("step_ret", r);
      b_rd = n_rd;
      repeat (12) tick();
      chk("step_parked_ret", retired, r);
      chk("step_parked_pc", pc, r);
      chk("step_parked_no_rd", n_rd - b_rd, 0);
      step = 1'b1; tick(); step = 1'b0;
    end
    wait_ret("step_ret4", 4);
    chk("step_ret_after_last", retired, 4);
`else
    // single MOV then HALT
    mem[0] = 16'hD105; mem[1] = 16'hE000;
    b_rd = n_rd; b_ld = n_ld; b_s = n_s;
    run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = halted | fault; end
    if (!ok) chk("halt_timeout", 0, 1);
    repeat (20) tick();
    chk("halt_loads", n_ld - b_ld, 1);
    chk("halt_load_data", last_ld, 16'hD105);
    chk("halt_s_pulses", n_s - b_s, 1);
    chk("halt_mem_rds", n_rd - b_rd, 2);
    chk("halt_pc", pc, 1);
    chk("halt_flag", halted, 1);
    chk("halt_retired", retired, 1);
    chk("halt_no_fault", fault, 0);

    // asynchronous reset in the middle of BUSY
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000;
    do_reset();
    wait_ret("ar_ret", 2);
    wait_s("ar_s");
    tick();
    reset = 1'b1; #1;
    chk("ar_pc", pc, 0);
    chk("ar_retired", retired, 0);
    chk("ar_strobes", {bus.mem_rd, bus.cpu_load, bus.cpu_s}, 0);
    chk("ar_cpu_in", bus.cpu_in, 0);
    tick(); reset = 1'b0;
    wait_rd("ar_restart");
    chk("ar_restart_addr", bus.mem_addr, 0);

    // busy timeout: cpu never drops w
    run = 1'b0; hang = 1'b1;
    do_reset();
    run = 1'b1;
    wait_s("to_s");
    k = 0;
    for (int i = 1; i <= T + 4 && k == 0; i++) begin tick(); if (fault) k = i; end
    chk("to_latency", k, T);
    b_rd = n_rd;
    repeat (10) tick();
    chk("to_fault", fault, 1);
    chk("to_pc", pc, 0);
    chk("to_halted", halted, 0);
    chk("to_stays_halted", n_rd - b_rd, 0);
    hang = 1'b0;

    // run dropped during BUSY of the instruction at pc=3
    run = 1'b0;
    do_reset();
    run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin wait_s("rd_s"); ok = (pc == 8'd3); end
    chk("rd_found_pc3", ok, 1);
    tick();
    run = 1'b0;
    wait_ret("rd_ret", 4);
    b_rd = n_rd;
    repeat (10) tick();
    chk("rd_pc", pc, 4);
    chk("rd_retired", retired, 4);
    chk("rd_no_fetch", n_rd - b_rd, 0);
    run = 1'b1;
    wait_rd("rd_resume");
    chk("rd_resume_addr", bus.mem_addr, 4);
    run = 1'b0;

    // ADDR_W=2 wrap, table driven
    do_reset();
    run2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin tick(); ok = (int'(retired2) >= vec[i].exp_ret); end
      if (!ok) chk("wrap_timeout", 0, 1);
      chk($sformatf("wrap_pc_%0d", i), pc2, vec[i].exp_pc);
      chk($sformatf("wrap_ret_%0d", i), retired2, vec[i].exp_ret);
      chk($sformatf("wrap_ld_%0d", i), last_ld2, vec[i].instr);
    end
    run2 = 1'b0;
`endif

    chk("load_s_rd_overlap", n_ovl, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
